ecc_error_logger: RTL and testbench
===================================

// Module: ecc_error_logger
// PURPOSE
//  Downstream consumer of the memory stage's Hamming ECC status (dmem_error / error_type_dmem).
//  Turns per-access error flags into a deduplicated event log: a DEPTH-entry show-ahead FIFO of
//  {addr, syndrome, double}, plus saturating single/double counters and a sticky overflow flag.
//  Instantiated in Pipeline_top next to the memory stage; the log is drained by a debug/CSR reader.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >= 2
//  ADDR_W  32  width of logged data-memory byte address
//  SYN_W   6   Hamming syndrome width
//  CNT_W   16  width of each saturating error counter
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  ev_valid     in   1       memory stage reports an ECC error this cycle (dmem_error)
//  ev_double    in   1       1 = uncorrectable double-bit, 0 = corrected single-bit (error_type_dmem)
//  ev_addr      in   ADDR_W  address of the faulting access
//  ev_syndrome  in   SYN_W   decoder syndrome of the faulting access
//  clear        in   1       sync clear: flush FIFO, zero counters, clear overflow (and irq)
//  rd_en        in   1       pop head entry; ignored when rd_valid = 0
//  rd_valid     out  1       FIFO non-empty; rd_* hold the head entry
//  rd_addr      out  ADDR_W  head entry address
//  rd_syndrome  out  SYN_W   head entry syndrome
//  rd_double    out  1       head entry type
//  level        out  $clog2(DEPTH)+1  entries currently held
//  cnt_single   out  CNT_W   accepted single-bit events, saturating
//  cnt_double   out  CNT_W   accepted double-bit events, saturating
//  overflow     out  1       sticky: an event was dropped due to a full FIFO
//  irq          out  1       interrupt request (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, async): FIFO empty, rd_valid=0, rd_* = 0, level=0, counters=0, overflow=0, irq=0.
//  - Dedup: an event is "new" when ev_valid=1 and, in the previous cycle, ev_valid=0 or
//    {ev_addr, ev_syndrome, ev_double} differed. A held flag for a stalled LW logs exactly once.
//    Previous-cycle tracking register resets to "no event".
//  - New event at edge N: counter for its type increments at edge N (saturates at 2^CNT_W-1,
//    never wraps); entry is pushed at edge N if the FIFO has room, so rd_valid/level reflect it
//    in cycle N+1. Counting is independent of FIFO room.
//  - Full FIFO, new event, no pop: entry dropped, overflow set at edge N; counters still count.
//  - Full FIFO, new event and rd_en same cycle: pop and push both occur; no overflow; level unchanged.
//  - Empty FIFO: rd_en ignored, no pointer movement. Never push and pop the same entry:
//    with empty FIFO and new event, the entry becomes head in cycle N+1.
//  - Pointers wrap modulo DEPTH; full/empty derived from an extra pointer MSB.
//  - clear wins over everything in its cycle: the same-cycle event is discarded and not counted;
//    the dedup tracker is reset so a still-held event re-logs the following cycle.
//  - rd_* are registered/array outputs of the head slot; when empty they hold 0.
// CONFIGURATION
//  ECC_LOG_IRQ_EN defined: irq is a registered sticky flag, set at the edge that accepts a
//    double-bit event or sets overflow; cleared only by clear or reset.
//  ECC_LOG_IRQ_EN undefined: irq tied to 0; no irq logic synthesised; all else identical.
// TESTING
//  1 Reset: hold rst=0 with ev_valid=1 -> all outputs 0; release -> first event logged next edge.
//  2 Single: ev_valid=1 for 1 cycle, addr=0x4, syn=0x03, double=0 -> next cycle rd_valid=1,
//    rd_addr=0x4, rd_syndrome=0x03, cnt_single=1, level=1; rd_en -> rd_valid=0, level=0.
//  3 Dedup: same event held 5 cycles -> level=1, cnt_single=1; then addr changes to 0x8 while
//    held -> level=2, cnt_single=2.
//  4 Overflow: 9 distinct events, DEPTH=8, no reads -> level=8, overflow=1, cnt_single=9,
//    head addr = first event; 10th event with rd_en same cycle -> level=8, tail = 10th event.
//  5 Clear/saturation: CNT_W=4, 20 double events -> cnt_double=15; clear with event same cycle
//    -> counters 0, level 0, overflow 0, event not logged.
//  6 IRQ: with ECC_LOG_IRQ_EN, one double event -> irq=1 next cycle, stays after pop, drops on
//    clear; without the macro, irq=0 throughout scenarios 1-5.

Source files
------------

// File: rtl/ecc_error_logger.sv
// ecc_error_logger: deduplicating ECC error event log (show-ahead FIFO, saturating counters, sticky overflow)
// Optional feature macro: ECC_LOG_IRQ_EN (registered sticky irq on double-bit event or overflow)
module ecc_error_logger #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int SYN_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ev_valid,
    input  logic                     ev_double,
    input  logic [ADDR_W-1:0]        ev_addr,
    input  logic [SYN_W-1:0]         ev_syndrome,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [SYN_W-1:0]         rd_syndrome,
    output logic                     rd_double,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         cnt_single,
    output logic [CNT_W-1:0]         cnt_double,
    output logic                     overflow,
    output logic                     irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = ADDR_W + SYN_W + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          prev_valid;
    logic [EW-1:0] prev_key, ev_key, head;
    logic          empty, full, is_new, pop, push, drop;

    assign ev_key = {ev_addr, ev_syndrome, ev_double};
    assign empty  = wr_ptr == rd_ptr;
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // clear discards the same-cycle event and any pop
    assign is_new = ev_valid && !clear && (!prev_valid || ev_key != prev_key);
    assign pop    = rd_en && !empty && !clear;
    assign push   = is_new && (!full || pop);
    assign drop   = is_new && full && !pop;
    assign head   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign {rd_addr, rd_syndrome, rd_double} = head;
    assign rd_valid = !empty;
    assign level    = wr_ptr - rd_ptr;

    // previous-cycle event tracker for dedup; clear forgets it so a held event re-logs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_valid <= 1'b0;
            prev_key   <= '0;
        end else begin
            prev_valid <= ev_valid && !clear;
            prev_key   <= ev_key;
        end
    end

    // FIFO pointers and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // saturating per-type counters, independent of FIFO room
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (clear) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else begin
            if (is_new && !ev_double && cnt_single != '1) cnt_single <= cnt_single + CNT_W'(1);
            if (is_new && ev_double && cnt_double != '1) cnt_double <= cnt_double + CNT_W'(1);
        end
    end

    // entry storage; unread slots are masked by empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= ev_key;
    end

`ifdef ECC_LOG_IRQ_EN
    // sticky interrupt on accepted double-bit event or dropped entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else if (clear) irq <= 1'b0;
        else if ((is_new && ev_double) || drop) irq <= 1'b1;
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_ecc_error_logger.sv
// tb_ecc_error_logger: directed table-driven and sequence checks for ecc_error_logger
module tb_ecc_error_logger;
`ifdef ECC_LOG_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ev_valid = 1'b0, ev_double = 1'b0, clear = 1'b0, rd_en = 1'b0;
    logic [31:0] ev_addr = '0;
    logic [5:0]  ev_syndrome = '0;
    logic        rd_valid, rd_double, overflow, irq;
    logic [31:0] rd_addr;
    logic [5:0]  rd_syndrome;
    logic [3:0]  level, cnt_single, cnt_double;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    ecc_error_logger #(.DEPTH(8), .ADDR_W(32), .SYN_W(6), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_double(ev_double), .ev_addr(ev_addr),
        .ev_syndrome(ev_syndrome), .clear(clear), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_addr(rd_addr), .rd_syndrome(rd_syndrome), .rd_double(rd_double), .level(level),
        .cnt_single(cnt_single), .cnt_double(cnt_double), .overflow(overflow), .irq(irq)
    );

    typedef struct {
        logic v, d; logic [31:0] a; logic [5:0] s; logic c, r;
        logic e_val; logic [31:0] e_addr; logic [5:0] e_syn; logic e_dbl;
        int e_lvl, e_cs, e_cd; logic e_ovf, e_irq;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, d, input logic [31:0] a, input logic [5:0] s, input logic c, r);
        @(negedge clk);
        ev_valid = v; ev_double = d; ev_addr = a; ev_syndrome = s; clear = c; rd_en = r;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic v, d, input logic [31:0] a, input logic [5:0] s,
                                input logic c, r, input logic e_val, input logic [31:0] e_addr,
                                input logic [5:0] e_syn, input logic e_dbl, input int e_lvl,
                                input int e_cs, input int e_cd, input logic e_ovf, input logic e_irq);
        vec_t t;
        t.v = v; t.d = d; t.a = a; t.s = s; t.c = c; t.r = r;
        t.e_val = e_val; t.e_addr = e_addr; t.e_syn = e_syn; t.e_dbl = e_dbl;
        t.e_lvl = e_lvl; t.e_cs = e_cs; t.e_cd = e_cd; t.e_ovf = e_ovf; t.e_irq = e_irq;
        vq.push_back(t);
    endfunction

    initial begin
        //  v  d  addr      syn   c  r   val addr      syn   dbl lvl cs cd ovf irq(if enabled)
        add(1, 0, 32'h04,   6'h03, 0, 0, 1, 32'h04,   6'h03, 0, 1, 1, 0, 0, 0);
        add(0, 0, 32'h00,   6'h00, 0, 1, 0, 32'h00,   6'h00, 0, 0, 1, 0, 0, 0);
        add(1, 0, 32'h10,   6'h05, 0, 0, 1, 32'h10,   6'h05, 0, 1, 2, 0, 0, 0);
        add(1, 0, 32'h10,   6'h05, 0, 0, 1, 32'h10,   6'h05, 0, 1, 2, 0, 0, 0);
        add(1, 0, 32'h10,   6'h05, 0, 0, 1, 32'h10,   6'h05, 0, 1, 2, 0, 0, 0);
        add(1, 0, 32'h10,   6'h05, 0, 0, 1, 32'h10,   6'h05, 0, 1, 2, 0, 0, 0);
        add(1, 0, 32'h10,   6'h05, 0, 0, 1, 32'h10,   6'h05, 0, 1, 2, 0, 0, 0);
        add(1, 0, 32'h08,   6'h05, 0, 0, 1, 32'h10,   6'h05, 0, 2, 3, 0, 0, 0);
        add(0, 0, 32'h00,   6'h00, 0, 1, 1, 32'h08,   6'h05, 0, 1, 3, 0, 0, 0);
        add(1, 0, 32'h08,   6'h05, 0, 0, 1, 32'h08,   6'h05, 0, 2, 4, 0, 0, 0);
        add(1, 1, 32'h08,   6'h05, 0, 0, 1, 32'h08,   6'h05, 0, 3, 4, 1, 0, 1);
        add(0, 0, 32'h00,   6'h00, 0, 1, 1, 32'h08,   6'h05, 0, 2, 4, 1, 0, 1);
        add(0, 0, 32'h00,   6'h00, 0, 1, 1, 32'h08,   6'h05, 1, 1, 4, 1, 0, 1);
        add(0, 0, 32'h00,   6'h00, 0, 1, 0, 32'h00,   6'h00, 0, 0, 4, 1, 0, 1);
        add(0, 0, 32'h00,   6'h00, 0, 1, 0, 32'h00,   6'h00, 0, 0, 4, 1, 0, 1);
        add(1, 0, 32'h20,   6'h01, 0, 1, 1, 32'h20,   6'h01, 0, 1, 5, 1, 0, 1);
        add(1, 0, 32'h20,   6'h01, 1, 0, 0, 32'h00,   6'h00, 0, 0, 0, 0, 0, 0);

        // reset held with an event present: everything stays zero
        ev_valid = 1; ev_addr = 32'h04; ev_syndrome = 6'h03;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_addr", rd_addr, 0);
        chk("reset level", level, 0);
        chk("reset cnt_single", cnt_single, 0);
        chk("reset overflow", overflow, 0);
        chk("reset irq", irq, 0);
        rst = 1;

        foreach (vq[i]) begin
            step(vq[i].v, vq[i].d, vq[i].a, vq[i].s, vq[i].c, vq[i].r);
            chk($sformatf("row%0d rd_valid", i), rd_valid, vq[i].e_val);
            chk($sformatf("row%0d rd_addr", i), rd_addr, vq[i].e_addr);
            chk($sformatf("row%0d rd_syndrome", i), rd_syndrome, vq[i].e_syn);
            chk($sformatf("row%0d rd_double", i), rd_double, vq[i].e_dbl);
            chk($sformatf("row%0d level", i), level, 64'(vq[i].e_lvl));
            chk($sformatf("row%0d cnt_single", i), cnt_single, 64'(vq[i].e_cs));
            chk($sformatf("row%0d cnt_double", i), cnt_double, 64'(vq[i].e_cd));
            chk($sformatf("row%0d overflow", i), overflow, vq[i].e_ovf);
            chk($sformatf("row%0d irq", i), irq, vq[i].e_irq & IRQ_EN);
        end

        // overflow: 9 distinct single events into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 32'h100 + 32'(4 * i), 6'(i), 0, 0);
            if (i == 7) begin
                chk("ovf 8th level", level, 8);
                chk("ovf 8th overflow", overflow, 0);
            end
        end
        chk("ovf level", level, 8);
        chk("ovf overflow", overflow, 1);
        chk("ovf cnt_single", cnt_single, 9);
        chk("ovf head", rd_addr, 32'h100);
        chk("ovf irq", irq, IRQ_EN);
        step(1, 0, 32'h200, 6'h2a, 0, 1);
        chk("full push+pop level", level, 8);
        chk("full push+pop head", rd_addr, 32'h104);
        chk("full push+pop cnt_single", cnt_single, 10);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d addr", i), rd_addr, (i < 7) ? 32'h104 + 32'(4 * i) : 32'h200);
            step(0, 0, 0, 0, 0, 1);
        end
        chk("drain level", level, 0);
        chk("drain rd_valid", rd_valid, 0);

        // saturation of the double counter, then clear with a simultaneous event
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 32'h300 + 32'(i), 6'h3f, 0, 0);
        chk("sat cnt_double", cnt_double, 15);
        chk("sat cnt_single", cnt_single, 0);
        step(1, 1, 32'h400, 6'h11, 1, 0);
        chk("clear level", level, 0);
        chk("clear rd_valid", rd_valid, 0);
        chk("clear cnt_double", cnt_double, 0);
        chk("clear overflow", overflow, 0);
        chk("clear irq", irq, 0);
        step(1, 1, 32'h400, 6'h11, 0, 0);
        chk("relog level", level, 1);
        chk("relog cnt_double", cnt_double, 1);
        chk("relog addr", rd_addr, 32'h400);

        // irq: set on a double event, survives a pop, dropped by clear
        step(0, 0, 0, 0, 1, 0);
        chk("irq after clear", irq, 0);
        step(1, 1, 32'h500, 6'h02, 0, 0);
        chk("irq on double", irq, IRQ_EN);
        step(0, 0, 0, 0, 0, 1);
        chk("irq after pop", irq, IRQ_EN);
        chk("irq pop level", level, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("irq cleared", irq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
